// File: rtl/dsp_ctrl_pkg.sv
// rtl/dsp_ctrl_pkg.sv - shared constants, tag type and index helper for the DSP slice arbiter
package dsp_ctrl_pkg;

  localparam int AW      = 18;
  localparam int CW      = 48;
  localparam int DSP_LAT = 4;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/dsp_slice_arbiter_if.sv
// rtl/dsp_slice_arbiter_if.sv - requester operand channels and tagged result channel
interface dsp_slice_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 18,
  parameter int CW   = 48,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*AW-1:0] req_b;
  logic [NREQ*AW-1:0] req_d;
  logic [NREQ*CW-1:0] req_c;

  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [CW-1:0]      rsp_p;

  modport master (
    output req_valid, req_a, req_b, req_d, req_c,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, req_d, req_c,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last winner
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  import dsp_ctrl_pkg::*;

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en) begin
      // Offsets 1..NREQ visit every requester once, the last winner last.
      for (int k = 1; k <= NREQ; k++) begin
        idx = rr_index(int'(ptr), k, NREQ);
        if (!gnt_any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
          gnt_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dsp_slice_arbiter.sv
// rtl/dsp_slice_arbiter.sv - shares one pipelined DSP slice among NREQ requesters,
// returning each result tagged with the requester that issued it
module dsp_slice_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = dsp_ctrl_pkg::DSP_LAT,
  parameter int AW   = dsp_ctrl_pkg::AW,
  parameter int CW   = dsp_ctrl_pkg::CW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  dsp_slice_arbiter_if.slave bus,
  output logic [AW-1:0]     dsp_a,
  output logic [AW-1:0]     dsp_b,
  output logic [AW-1:0]     dsp_d,
  output logic [CW-1:0]     dsp_c,
  input  logic [CW-1:0]     dsp_p,
  output logic              busy,
  output logic [15:0]       issue_cnt
);

  import dsp_ctrl_pkg::*;

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;

  // tags[0] sits alongside the dsp_* registers; tags[LAT] lines up with dsp_p.
  tag_t tags [0:LAT];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .en      (en && !rst),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // The arbiter only grants a valid requester, so any grant is an issue.
  assign bus.req_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= IDW'(NREQ - 1);
      dsp_a         <= '0;
      dsp_b         <= '0;
      dsp_d         <= '0;
      dsp_c         <= '0;
      issue_cnt     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_p     <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      if (gnt_any) begin
        ptr       <= gnt_id;
        dsp_a     <= bus.req_a[gnt_id*AW +: AW];
        dsp_b     <= bus.req_b[gnt_id*AW +: AW];
        dsp_d     <= bus.req_d[gnt_id*AW +: AW];
        dsp_c     <= bus.req_c[gnt_id*CW +: CW];
        tags[0]   <= '{v: 1'b1, id: TAG_IDW'(gnt_id)};
        issue_cnt <= issue_cnt + 16'd1;
      end else begin
        dsp_a   <= '0;
        dsp_b   <= '0;
        dsp_d   <= '0;
        dsp_c   <= '0;
        tags[0] <= '0;
      end
      for (int k = 1; k <= LAT; k++) begin
        tags[k] <= tags[k-1];
      end
      bus.rsp_valid <= tags[LAT].v;
      if (tags[LAT].v) begin
        bus.rsp_id <= tags[LAT].id[IDW-1:0];
        bus.rsp_p  <= dsp_p;
      end
    end
  end

  always_comb begin
    busy = bus.rsp_valid;
    for (int k = 0; k <= LAT; k++) begin
      busy = busy | tags[k].v;
    end
  end

endmodule

// File: tb/tb_dsp_slice_arbiter.sv
// tb/tb_dsp_slice_arbiter.sv - scoreboard bench for dsp_slice_arbiter with a behavioural DSP
module tb_dsp_slice_arbiter;

  import dsp_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int L  = DSP_LAT;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] dsp_a, dsp_b, dsp_d;
  logic [CW-1:0] dsp_c, dsp_p;
  logic          busy;
  logic [15:0]   issue_cnt;

  always #5 clk = ~clk;

  dsp_slice_arbiter_if #(.NREQ(N), .AW(AW), .CW(CW), .IDW(IW)) bus ();

  dsp_slice_arbiter #(
    .NREQ (N), .LAT (L), .AW (AW), .CW (CW), .IDW (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_d     (dsp_d),
    .dsp_c     (dsp_c),
    .dsp_p     (dsp_p),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  // Behavioural DSP: L registers from the dsp_* inputs to dsp_p, reset with the block.
  logic [CW-1:0] dpipe [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) dpipe[k] <= '0;
    end else begin
      dpipe[0] <= (CW'(dsp_d) + CW'(dsp_a)) * CW'(dsp_b) + dsp_c;
      for (int k = 1; k < L; k++) dpipe[k] <= dpipe[k-1];
    end
  end
  assign dsp_p = dpipe[L-1];

  typedef struct {
    int            id;
    logic [CW-1:0] p;
    int            due;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          passes   = 0;
  int          cyc      = 0;
  int          last_win = N - 1;
  int          n_issued = 0;
  logic [15:0] cnt_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: predicts the grant from the round-robin rule, checks it, and scores responses.
  always @(negedge clk) begin : monitor
    logic [N-1:0] eg;
    int           w;
    int           i;
    exp_t         e;
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("issue_cnt", 64'(issue_cnt), 64'(cnt_model));
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_p", 64'(bus.rsp_p), 64'(e.p));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
    eg = '0;
    w  = -1;
    if (en && !rst) begin
      for (int k = 1; k <= N; k++) begin
        i = (last_win + k) % N;
        if (w < 0 && bus.req_valid[i]) w = i;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    if (w >= 0) begin
      e.id  = w;
      e.p   = (CW'(bus.req_d[w*AW +: AW]) + CW'(bus.req_a[w*AW +: AW]))
              * CW'(bus.req_b[w*AW +: AW]) + bus.req_c[w*CW +: CW];
      e.due = cyc + L + 2;
      q.push_back(e);
      last_win  = w;
      cnt_model = cnt_model + 16'd1;
      n_issued++;
    end
    if (rst) begin
      q.delete();
      last_win  = N - 1;
      cnt_model = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*AW +: AW] = AW'($urandom);
      bus.req_b[i*AW +: AW] = AW'($urandom);
      bus.req_d[i*AW +: AW] = AW'($urandom);
      bus.req_c[i*CW +: CW] = CW'({$urandom, $urandom});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dsp_a"}, 64'(dsp_a), 64'(0));
    chk({tag, "_dsp_b"}, 64'(dsp_b), 64'(0));
    chk({tag, "_dsp_d"}, 64'(dsp_d), 64'(0));
    chk({tag, "_dsp_c"}, 64'(dsp_c), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
    chk({tag, "_rsp_p"}, 64'(bus.rsp_p), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_issue_cnt"}, 64'(issue_cnt), 64'(0));
  endtask

  initial begin
    int c0;
    int start;
    rst = 1'b1;
    en  = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_d = '0;
    bus.req_c = '0;
    step();
    step();
    rst = 1'b0;
    check_reset_values("rst0");

    // Single op: (2+3)*5+7 = 32, six cycles after the handshake.
    bus.req_a[0 +: AW] = AW'(3);
    bus.req_d[0 +: AW] = AW'(2);
    bus.req_b[0 +: AW] = AW'(5);
    bus.req_c[0 +: CW] = CW'(7);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
    c0 = cyc;
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 12 && !bus.rsp_valid; i++) step();
    chk("t1_rsp_seen", 64'(bus.rsp_valid), 64'(1));
    chk("t1_p", 64'(bus.rsp_p), 64'(32));
    chk("t1_id", 64'(bus.rsp_id), 64'(0));
    chk("t1_latency", 64'(cyc - c0), 64'(6));
    idle(3);

    // All four valid for eight cycles from a fresh pointer.
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1;
      chk("t2_gnt", 64'(bus.req_ready), 64'(4'b0001 << (i % 4)));
      step();
    end
    bus.req_valid = '0;
    idle(10);
    chk("t2_issue_cnt", 64'(issue_cnt), 64'(8));

    // Lone requester 2 streams back to back, then 1 and 3 compete.
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      #1;
      chk("t3_gnt2", 64'(bus.req_ready), 64'(4'b0100));
      step();
    end
    bus.req_valid = 4'b1010;
    rand_ops();
    #1;
    chk("t3_gnt3", 64'(bus.req_ready), 64'(4'b1000));
    step();
    rand_ops();
    #1;
    chk("t3_gnt1", 64'(bus.req_ready), 64'(4'b0010));
    step();
    bus.req_valid = '0;
    idle(10);

    // en low: no grants while in-flight ops drain.
    bus.req_valid = 4'b1111;
    rand_ops();
    step();
    rand_ops();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      #1;
      chk("t4_no_gnt", 64'(bus.req_ready), 64'(0));
      step();
    end
    chk("t4_busy_low", 64'(busy), 64'(0));
    en = 1'b1;
    bus.req_valid = '0;
    idle(2);

    // Reset with three ops in flight: none of them may respond.
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    idle(2);
    do_reset();
    check_reset_values("t5");
    for (int i = 0; i < 8; i++) begin
      chk("t5_no_rsp", 64'(bus.rsp_valid), 64'(0));
      step();
    end
    bus.req_valid = 4'b1111;
    rand_ops();
    #1;
    chk("t5_first_gnt", 64'(bus.req_ready), 64'(4'b0001));
    step();
    bus.req_valid = '0;
    idle(10);

    // issue_cnt wraps after 65536 issues.
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 65535; i++) begin
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    idle(8);
    chk("t6_cnt_max", 64'(issue_cnt), 64'(16'hFFFF));
    bus.req_valid = 4'b0001;
    rand_ops();
    step();
    bus.req_valid = '0;
    idle(8);
    chk("t6_cnt_wrap", 64'(issue_cnt), 64'(0));

    // Random traffic with random en until 1000 more ops have issued.
    start = n_issued;
    for (int i = 0; i < 6000 && (n_issued - start) < 1000; i++) begin
      bus.req_valid = N'($urandom);
      en = ($urandom_range(0, 7) != 0);
      rand_ops();
      step();
    end
    chk("t6_rand_ops_done", 64'((n_issued - start) >= 1000), 64'(1));
    en = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("t6_drain_empty", 64'(q.size()), 64'(0));
    step();
    chk("t6_busy_low", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
